mem_wb_pipe: RTL and testbench

//  Elastic MEM->WB pipeline stage: parametrised payload and valid/ready handshake.
//  2-entry skid buffer, so in_ready is a registered output (no combinational ready path).

---
 rtl/mem_wb_pkg.sv | 23 ++
 rtl/mem_wb_skid_buf.sv | 84 ++++++++
 rtl/mem_wb_pipe.sv | 97 +++++++++
 tb/tb_mem_wb_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM->WB pipeline stage: default payload layout and skid-buffer states.
package mem_wb_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned RegAddrW = 5;

  typedef struct packed {
    logic [DataW-1:0]    data_mem;
    logic [DataW-1:0]    alu;
    logic [RegAddrW-1:0] reg_addr;
    logic                memtoreg;
    logic                regwrite;
  } mem_wb_payload_t;

  localparam int unsigned PayloadW = $bits(mem_wb_payload_t);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } skid_state_t;

endpackage

// File: rtl/mem_wb_skid_buf.sv
// Generic 2-entry skid buffer with registered ready/valid and synchronous flush.
module mem_wb_skid_buf
  import mem_wb_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = PayloadW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  skid_state_t          state_q;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 accept;
  logic                 pop;

  always_comb begin
    accept = in_valid & in_ready_q;
    pop    = out_valid_q & out_ready;
  end

  // in_ready/out_valid are registered alongside the state so neither depends on the far side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q      <= in_data;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            skid_q     <= in_data;
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end else if (pop && !accept) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end else if (accept && pop) begin
            main_q <= in_data;
          end
        end
        FULL: begin
          if (pop) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// Elastic MEM->WB stage: skid-buffered payload, write-back mux, x0 gating, forwarding.
// Define MEM_WB_PERF_EN to add saturating perf_retired/perf_stall counters.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W     = DataW,
  parameter int unsigned REG_ADDR_W = RegAddrW,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data_mem,
  input  logic [DATA_W-1:0]     in_alu,
  input  logic [REG_ADDR_W-1:0] in_reg_addr,
  input  logic                  in_memtoreg,
  input  logic                  in_regwrite,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_wdata,
  output logic [REG_ADDR_W-1:0] out_reg_addr,
  output logic                  out_regwrite,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg_addr,
  output logic [DATA_W-1:0]     fwd_wdata
`ifdef MEM_WB_PERF_EN
  ,
  output logic [CNT_W-1:0]      perf_retired,
  output logic [CNT_W-1:0]      perf_stall
`endif
);

  // Same field order as mem_wb_payload_t, but sized by this instance's parameters.
  localparam int unsigned PAYLOAD_W = 2 * DATA_W + REG_ADDR_W + 2;

  logic [PAYLOAD_W-1:0]  in_payload;
  logic [PAYLOAD_W-1:0]  head_payload;
  logic [DATA_W-1:0]     head_data_mem;
  logic [DATA_W-1:0]     head_alu;
  logic [REG_ADDR_W-1:0] head_reg_addr;
  logic                  head_memtoreg;
  logic                  head_regwrite;

  assign in_payload = {in_data_mem, in_alu, in_reg_addr, in_memtoreg, in_regwrite};
  assign {head_data_mem, head_alu, head_reg_addr, head_memtoreg, head_regwrite} = head_payload;

  mem_wb_skid_buf #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_skid_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_payload),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head_payload)
  );

  always_comb begin
    out_wdata    = head_memtoreg ? head_data_mem : head_alu;
    out_reg_addr = head_reg_addr;
    out_regwrite = head_regwrite & out_valid & (head_reg_addr != '0);
    fwd_valid    = out_valid & out_regwrite;
    fwd_reg_addr = out_reg_addr;
    fwd_wdata    = out_wdata;
  end

`ifdef MEM_WB_PERF_EN
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] stall_q;

  // A pop in a flush cycle still retires the head, so flush is deliberately not a term here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (out_valid && out_ready && out_regwrite && !(&retired_q)) begin
        retired_q <= retired_q + CntOne;
      end
      if (out_valid && !out_ready && !(&stall_q)) begin
        stall_q <= stall_q + CntOne;
      end
    end
  end

  assign perf_retired = retired_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Randomized self-checking bench for mem_wb_pipe against a queue-based reference model.
module tb_mem_wb_pipe;

  typedef struct {
    logic [31:0] data_mem;
    logic [31:0] alu;
    logic [4:0]  reg_addr;
    logic        memtoreg;
    logic        regwrite;
  } entry_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data_mem;
  logic [31:0] in_alu;
  logic [4:0]  in_reg_addr;
  logic        in_memtoreg;
  logic        in_regwrite;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_wdata;
  logic [4:0]  out_reg_addr;
  logic        out_regwrite;
  logic        fwd_valid;
  logic [4:0]  fwd_reg_addr;
  logic [31:0] fwd_wdata;
`ifdef MEM_WB_PERF_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_stall;
`endif

  mem_wb_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data_mem (in_data_mem),
    .in_alu      (in_alu),
    .in_reg_addr (in_reg_addr),
    .in_memtoreg (in_memtoreg),
    .in_regwrite (in_regwrite),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_wdata   (out_wdata),
    .out_reg_addr(out_reg_addr),
    .out_regwrite(out_regwrite),
    .fwd_valid   (fwd_valid),
    .fwd_reg_addr(fwd_reg_addr),
    .fwd_wdata   (fwd_wdata)
`ifdef MEM_WB_PERF_EN
    ,
    .perf_retired(perf_retired),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  entry_t      model_q[$];
  int unsigned model_retired = 0;
  int unsigned model_stall   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic entry_t rand_entry();
    entry_t e;
    logic [31:0] r;
    r          = $urandom;
    e.data_mem = $urandom;
    e.alu      = $urandom;
    e.reg_addr = r[4:0];
    e.memtoreg = r[8];
    e.regwrite = r[9];
    return e;
  endfunction

  function automatic entry_t mk_entry(logic [31:0] dm, logic [31:0] alu, logic [4:0] ra,
                                      logic m2r, logic rw);
    entry_t e;
    e.data_mem = dm;
    e.alu      = alu;
    e.reg_addr = ra;
    e.memtoreg = m2r;
    e.regwrite = rw;
    return e;
  endfunction

  // Outputs implied by the model queue; payload fields only meaningful when an entry is held.
  task automatic check_outputs();
    logic        exp_valid;
    logic        exp_rw;
    logic [31:0] exp_wdata;
    entry_t      h;
    exp_valid = (model_q.size() > 0);
    check_eq("out_valid", 64'(out_valid), 64'(exp_valid));
    check_eq("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
    if (exp_valid) begin
      h         = model_q[0];
      exp_wdata = h.memtoreg ? h.data_mem : h.alu;
      exp_rw    = h.regwrite && (h.reg_addr != 5'd0);
      check_eq("out_wdata", 64'(out_wdata), 64'(exp_wdata));
      check_eq("out_reg_addr", 64'(out_reg_addr), 64'(h.reg_addr));
      check_eq("fwd_wdata", 64'(fwd_wdata), 64'(exp_wdata));
      check_eq("fwd_reg_addr", 64'(fwd_reg_addr), 64'(h.reg_addr));
    end else begin
      exp_rw = 1'b0;
    end
    check_eq("out_regwrite", 64'(out_regwrite), 64'(exp_rw));
    check_eq("fwd_valid", 64'(fwd_valid), 64'(exp_rw));
`ifdef MEM_WB_PERF_EN
    check_eq("perf_retired", 64'(perf_retired), 64'(model_retired));
    check_eq("perf_stall", 64'(perf_stall), 64'(model_stall));
`endif
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model, check after the edge.
  task automatic drive_cycle(input logic iv, input entry_t e, input logic ordy, input logic fl);
    logic acc;
    logic pop;
    in_valid    = iv;
    in_data_mem = e.data_mem;
    in_alu      = e.alu;
    in_reg_addr = e.reg_addr;
    in_memtoreg = e.memtoreg;
    in_regwrite = e.regwrite;
    out_ready   = ordy;
    flush       = fl;
    acc = iv && (model_q.size() < 2);
    pop = (model_q.size() > 0) && ordy;
    if (pop && model_q[0].regwrite && model_q[0].reg_addr != 5'd0) model_retired++;
    if ((model_q.size() > 0) && !ordy) model_stall++;
    if (fl) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (acc) model_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst out_valid", 64'(out_valid), 64'd0);
    check_eq("rst in_ready", 64'(in_ready), 64'd1);
    check_eq("rst out_wdata", 64'(out_wdata), 64'd0);
    check_eq("rst out_reg_addr", 64'(out_reg_addr), 64'd0);
    check_eq("rst out_regwrite", 64'(out_regwrite), 64'd0);
    check_eq("rst fwd_valid", 64'(fwd_valid), 64'd0);
    check_eq("rst fwd_wdata", 64'(fwd_wdata), 64'd0);
`ifdef MEM_WB_PERF_EN
    check_eq("rst perf_retired", 64'(perf_retired), 64'd0);
    check_eq("rst perf_stall", 64'(perf_stall), 64'd0);
`endif
    model_q.delete();
    model_retired = 0;
    model_stall   = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  entry_t idle;
  entry_t e;

  initial begin
    idle = mk_entry(32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data_mem = '0; in_alu = '0; in_reg_addr = '0; in_memtoreg = 1'b0; in_regwrite = 1'b0;
    @(negedge clk);
    apply_reset();

    // Reset while FULL
    drive_cycle(1'b1, rand_entry(), 1'b0, 1'b0);
    drive_cycle(1'b1, rand_entry(), 1'b0, 1'b0);
    check_eq("full in_ready", 64'(in_ready), 64'd0);
    apply_reset();

    // Perf: 3 retiring pops and 2 stall cycles from a fresh reset
    drive_cycle(1'b1, mk_entry(32'h0, 32'h11, 5'd1, 1'b0, 1'b1), 1'b0, 1'b0);
    drive_cycle(1'b0, idle, 1'b0, 1'b0);
    drive_cycle(1'b0, idle, 1'b0, 1'b0);
    drive_cycle(1'b1, mk_entry(32'h0, 32'h22, 5'd2, 1'b0, 1'b1), 1'b1, 1'b0);
    drive_cycle(1'b1, mk_entry(32'h0, 32'h33, 5'd3, 1'b0, 1'b1), 1'b1, 1'b0);
    drive_cycle(1'b0, idle, 1'b1, 1'b0);
`ifdef MEM_WB_PERF_EN
    check_eq("perf3 retired", 64'(perf_retired), 64'd3);
    check_eq("perf3 stall", 64'(perf_stall), 64'd2);
`endif

    // Streaming: ALU results 1..4 back-to-back
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(1'b1, mk_entry(32'hFFFF_0000, 32'(i), 5'd9, 1'b0, 1'b1), 1'b1, 1'b0);
      check_eq("stream wdata", 64'(out_wdata), 64'(i));
      check_eq("stream in_ready", 64'(in_ready), 64'd1);
    end
    drive_cycle(1'b0, idle, 1'b1, 1'b0);

    // Backpressure: A,B fill the buffer, C waits at the input until space frees
    drive_cycle(1'b1, mk_entry(32'h0, 32'hA, 5'd4, 1'b0, 1'b1), 1'b0, 1'b0);
    drive_cycle(1'b1, mk_entry(32'h0, 32'hB, 5'd4, 1'b0, 1'b1), 1'b0, 1'b0);
    check_eq("bp in_ready", 64'(in_ready), 64'd0);
    e = mk_entry(32'h0, 32'hC, 5'd4, 1'b0, 1'b1);
    drive_cycle(1'b1, e, 1'b0, 1'b0);
    check_eq("bp hold A", 64'(out_wdata), 64'hA);
    drive_cycle(1'b1, e, 1'b1, 1'b0);
    check_eq("bp B", 64'(out_wdata), 64'hB);
    drive_cycle(1'b1, e, 1'b1, 1'b0);
    check_eq("bp C", 64'(out_wdata), 64'hC);
    drive_cycle(1'b0, idle, 1'b1, 1'b0);
    check_eq("bp drained", 64'(out_valid), 64'd0);

    // Flush in state ONE with a simultaneous accept
    drive_cycle(1'b1, mk_entry(32'h0, 32'h55, 5'd5, 1'b0, 1'b1), 1'b0, 1'b0);
    drive_cycle(1'b1, mk_entry(32'h0, 32'h66, 5'd6, 1'b0, 1'b1), 1'b0, 1'b1);
    check_eq("flush out_valid", 64'(out_valid), 64'd0);
    check_eq("flush in_ready", 64'(in_ready), 64'd1);
    drive_cycle(1'b0, idle, 1'b1, 1'b0);
    check_eq("flush no ghost", 64'(out_valid), 64'd0);

    // x0 gating and memtoreg mux
    drive_cycle(1'b1, mk_entry(32'h1234, 32'h5678, 5'd0, 1'b0, 1'b1), 1'b0, 1'b0);
    check_eq("x0 regwrite", 64'(out_regwrite), 64'd0);
    check_eq("x0 fwd_valid", 64'(fwd_valid), 64'd0);
    drive_cycle(1'b1, mk_entry(32'hDEADBEEF, 32'h0BAD, 5'd7, 1'b1, 1'b1), 1'b1, 1'b0);
    check_eq("m2r fwd_wdata", 64'(fwd_wdata), 64'hDEADBEEF);
    check_eq("m2r fwd_valid", 64'(fwd_valid), 64'd1);
    check_eq("m2r fwd_addr", 64'(fwd_reg_addr), 64'd7);
    drive_cycle(1'b0, idle, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'($urandom_range(0, 3) != 0), rand_entry(), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 24) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
